// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared FSM type, default widths and LFSR taps for the adder operand sequencer
package adder_seq_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, CHECK, DONE} state_e;
    localparam int DEF_W = 3;
    localparam int DEF_CNT_W = 16;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/operand_gen.sv
// operand_gen: operand pair source; 2W-bit up-counter by default, 8-bit Fibonacci LFSR under OPERAND_LFSR_EN
module operand_gen
    import adder_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);
`ifdef OPERAND_LFSR_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else if (adv_i) lfsr <= lfsr_next(lfsr);
    end
    assign a_o = lfsr[W-1:0];
    assign b_o = lfsr[2*W-1:W];
`else
    logic [2*W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (adv_i) cnt <= cnt + (2*W)'(1);
    end
    assign {a_o, b_o} = cnt;
`endif
endmodule

// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: drives operand pairs into an external adder, checks the sums and counts pass/fail.
// Operand source is a counter by default; define OPERAND_LFSR_EN to use the LFSR instead.
module adder_op_sequencer
    import adder_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_ops_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    input  logic [W:0]       y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    state_e state, state_nxt;
    logic [CNT_W-1:0] n_lat, op_cnt;
    logic [W:0] y_cap;
    logic [W-1:0] gen_a, gen_b;
    logic accept, last, load, match;
    assign accept = state == IDLE && start_i && num_ops_i != '0;
    assign last = op_cnt == n_lat - CNT_W'(1);
    assign match = y_cap == {1'b0, a_o} + {1'b0, b_o};
    // every load consumes a pair, so the generator always points at the next unused one
    assign load = accept || (state == CHECK && !last);
    operand_gen #(.W(W), .LFSR_SEED(LFSR_SEED)) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (load),
        .a_o   (gen_a),
        .b_o   (gen_b)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? DRIVE : IDLE;
            DRIVE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CHECK;
            CHECK:   state_nxt = last ? DONE : DRIVE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        busy_o = state != IDLE;
        done_o = state == DONE;
        mismatch_o = state == CHECK && !match;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o <= '0;
            b_o <= '0;
            n_lat <= '0;
            op_cnt <= '0;
            y_cap <= '0;
            pass_cnt_o <= '0;
            err_cnt_o <= '0;
        end else begin
            if (load) begin
                a_o <= gen_a;
                b_o <= gen_b;
            end
            if (accept) begin
                n_lat <= num_ops_i;
                op_cnt <= '0;
                pass_cnt_o <= '0;
                err_cnt_o <= '0;
            end
            if (state == SAMPLE) y_cap <= y_i;
            if (state == CHECK) begin
                if (match) pass_cnt_o <= pass_cnt_o + CNT_W'(pass_cnt_o != '1);
                else err_cnt_o <= err_cnt_o + CNT_W'(err_cnt_o != '1);
                if (!last) op_cnt <= op_cnt + CNT_W'(1);
            end
        end
    end
endmodule
